prog_counter: RTL and testbench
===============================

// Module: prog_counter
// PURPOSE
//   Program counter / fetch sequencer of the core; consumes the 8-bit Target from the jump LUT.
//   Holds the current instruction address, advances it each cycle, redirects on absolute jumps
//   and relative branches, and frames each program run with a Start/Done handshake.
//   Drives the instruction-ROM address and reports the run length in cycles to the testbench.
// PARAMETERS
//   PC_W       10   width of ProgCounter (instruction ROM depth 2**PC_W)
//   START_ADDR 0    address loaded on reset and on every accepted Start
//   CNT_W      16   width of CycleCount
// PORTS
//   Clk         in   1      rising-edge clock
//   Reset_n     in   1      asynchronous, active-low reset
//   Start       in   1      begin a run; sampled in IDLE or DONE only
//   Stall       in   1      hold PC this cycle (RUN only)
//   Jump        in   1      absolute jump: PC <= zero-extended Target
//   BranchRel   in   1      taken relative branch: PC <= PC + sign-extended Target
//   Halt        in   1      decoded halt instruction at current PC
//   Target      in   8      jump-LUT output for the current instruction
//   ProgCounter out  PC_W   instruction address to ROM
//   Running     out  1      1 while in RUN
//   Done        out  1      1 while in DONE
//   CycleCount  out  CNT_W  cycles spent in RUN for the current/last run
// BEHAVIOUR
//   Reset (async, Reset_n=0): state IDLE, ProgCounter=START_ADDR, Running=0, Done=0, CycleCount=0.
//   FSM states IDLE, RUN, DONE; all outputs registered; Running/Done decoded from state register.
//   IDLE: PC held. Start=1 -> RUN next cycle, PC<=START_ADDR, CycleCount<=0.
//   RUN, one action per cycle, fixed priority:
//     1 Halt      -> DONE next cycle; PC held at halt address; CycleCount counts this cycle.
//     2 Stall     -> PC held.
//     3 Jump      -> PC <= {0, Target} (Target zero-extended to PC_W).
//     4 BranchRel -> PC <= PC + {{(PC_W-8){Target[7]}}, Target}, modulo 2**PC_W.
//     5 otherwise -> PC <= PC + 1, modulo 2**PC_W (wraps 2**PC_W-1 -> 0).
//   Jump and BranchRel both high: Jump wins. Stall overrides Jump/BranchRel (redirect lost,
//     upstream re-asserts). Halt overrides Stall.
//   Start while in RUN: ignored. Inputs other than Start/Reset_n ignored in IDLE and DONE.
//   CycleCount: +1 every RUN cycle (stall cycles included); saturates at 2**CNT_W-1, no wrap.
//   DONE: Done=1, PC and CycleCount frozen. Start=1 -> RUN next cycle, PC<=START_ADDR,
//     CycleCount<=0, Done falls the same edge.
//   Latency: redirect visible on ProgCounter one cycle after Jump/BranchRel sampled.
//   Reset_n low mid-run: immediate return to reset values, no wait for a clock edge.
//   PC_W must be >= 8; no X on outputs after reset for any input combination.
// TESTING
//   T1 reset/start: Reset_n low 2 cyc, Start pulse -> PC 0,1,2,3 on successive cycles,
//      Running=1, Done=0.
//   T2 absolute jump: at PC=5 Jump=1, Target=8'h0F -> next PC=15, then 16.
//   T3 relative: at PC=20 BranchRel=1, Target=8'hFF -> PC=19; Target=8'h03 from PC=19 -> PC=22;
//      from PC=2 Target=8'hFC -> PC=1022 (PC_W=10 wrap).
//   T4 priority: Jump+BranchRel same cycle, Target=8'h1F -> PC=31; Stall+Jump -> PC held;
//      Halt+Stall -> DONE.
//   T5 halt/restart: Start, 7 cycles run, Halt at PC=6 -> Done=1, CycleCount=7, PC=6 frozen
//      10 cyc; Start -> PC=0, CycleCount=0, Done=0.
//   T6 async reset mid-run: drop Reset_n between edges at PC=9 -> PC=0, state IDLE before
//      next edge; CycleCount saturation with CNT_W=4 -> holds at 15.

Source files
------------

// File: rtl/prog_counter.sv
// Program counter / fetch sequencer: IDLE -> RUN -> DONE run framing, absolute jumps,
// relative branches, stall/halt handling and a saturating run-length cycle counter.
module prog_counter #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Jump,
    input  logic             BranchRel,
    input  logic             Halt,
    input  logic [7:0]       Target,
    output logic [PC_W-1:0]  ProgCounter,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic signed [7:0]  w_tgt_s;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_tgt_s = Target;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = START_PC;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                w_cnt_nxt = sat_inc(r_cnt);
                // Halt beats Stall; a stalled redirect is dropped and re-issued upstream.
                if (Halt) begin
                    w_state_nxt = S_DONE;
                end else if (!Stall) begin
                    if (Jump)
                        w_pc_nxt = PC_W'(Target);
                    else if (BranchRel)
                        w_pc_nxt = r_pc + PC_W'(w_tgt_s);
                    else
                        w_pc_nxt = r_pc + PC_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= START_PC;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign ProgCounter = r_pc;
    assign CycleCount  = r_cnt;
    assign Running     = (r_state == S_RUN);
    assign Done        = (r_state == S_DONE);

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: integer-arithmetic reference model compared every cycle,
// plus literal expectations for each scenario (jumps, branches, priority, halt, async reset).
module tb_prog_counter;

    localparam int PC_W  = 10;
    localparam int PCM   = 1 << PC_W;
    localparam int CMAX  = 65535;
    localparam int CMAX4 = 15;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0;
    logic       Stall = 1'b0;
    logic       Jump = 1'b0;
    logic       BranchRel = 1'b0;
    logic       Halt = 1'b0;
    logic [7:0] Target = 8'h00;

    logic [PC_W-1:0] pc_a, pc_b;
    logic            run_a, run_b, done_a, done_b;
    logic [15:0]     cnt_a;
    logic [3:0]      cnt_b;

    int  n_vec = 0;
    int  n_bad = 0;
    bit  chk_en = 1'b0;

    int  m_pc = 0;
    bit  m_run = 1'b0;
    bit  m_done = 1'b0;
    int  m_cnt = 0;
    int  m_cnt4 = 0;

    prog_counter #(.PC_W(PC_W), .START_ADDR(0), .CNT_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Jump(Jump),
        .BranchRel(BranchRel), .Halt(Halt), .Target(Target),
        .ProgCounter(pc_a), .Running(run_a), .Done(done_a), .CycleCount(cnt_a)
    );

    prog_counter #(.PC_W(PC_W), .START_ADDR(0), .CNT_W(4)) dut_sat (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Jump(Jump),
        .BranchRel(BranchRel), .Halt(Halt), .Target(Target),
        .ProgCounter(pc_b), .Running(run_b), .Done(done_b), .CycleCount(cnt_b)
    );

    always #5 Clk = ~Clk;

    function automatic int sx8(input logic [7:0] t);
        return (t >= 8'd128) ? int'(t) - 256 : int'(t);
    endfunction

    function automatic int wrap_pc(input int v);
        return ((v % PCM) + PCM) % PCM;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: PC as a plain integer modulo 2**PC_W, run state as two flags.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_pc   <= 0;
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_cnt4 <= 0;
        end else if (!m_run) begin
            if (Start) begin
                m_run  <= 1'b1;
                m_done <= 1'b0;
                m_pc   <= 0;
                m_cnt  <= 0;
                m_cnt4 <= 0;
            end
        end else begin
            m_cnt  <= sat(m_cnt + 1, CMAX);
            m_cnt4 <= sat(m_cnt4 + 1, CMAX4);
            if (Halt) begin
                m_run  <= 1'b0;
                m_done <= 1'b1;
            end else if (!Stall) begin
                if (Jump)           m_pc <= int'(Target);
                else if (BranchRel) m_pc <= wrap_pc(m_pc + sx8(Target));
                else                m_pc <= wrap_pc(m_pc + 1);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("model_pc",    int'(pc_a),   m_pc);
            chk("model_run",   int'(run_a),  int'(m_run));
            chk("model_done",  int'(done_a), int'(m_done));
            chk("model_cnt",   int'(cnt_a),  m_cnt);
            chk("model_pc4",   int'(pc_b),   m_pc);
            chk("model_run4",  int'(run_b),  int'(m_run));
            chk("model_done4", int'(done_b), int'(m_done));
            chk("model_cnt4",  int'(cnt_b),  m_cnt4);
        end
    end

    // Drive one cycle of inputs right after a falling edge, return at the next falling edge.
    task automatic step(input logic st, input logic sl, input logic j, input logic br,
                        input logic h, input logic [7:0] t);
        Start = st; Stall = sl; Jump = j; BranchRel = br; Halt = h; Target = t;
        @(negedge Clk);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        @(negedge Clk);
        chk_en = 1'b1;
        @(negedge Clk);
        chk("rst_pc", int'(pc_a), 0);
        chk("rst_run", int'(run_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);
        Reset_n = 1'b1;

        // T1 start and sequential fetch
        step(1, 0, 0, 0, 0, 8'h00);
        chk("t1_pc0", int'(pc_a), 0);
        chk("t1_running", int'(run_a), 1);
        chk("t1_done", int'(done_a), 0);
        nop(1); chk("t1_pc1", int'(pc_a), 1);
        nop(1); chk("t1_pc2", int'(pc_a), 2);
        nop(1); chk("t1_pc3", int'(pc_a), 3);
        chk("t1_cnt", int'(cnt_a), 3);

        // T2 absolute jump from PC=5
        nop(2); chk("t2_pc5", int'(pc_a), 5);
        step(0, 0, 1, 0, 0, 8'h0F); chk("t2_jump", int'(pc_a), 15);
        nop(1); chk("t2_after", int'(pc_a), 16);

        // T3 relative branches, including wrap below zero
        nop(4); chk("t3_pc20", int'(pc_a), 20);
        step(0, 0, 0, 1, 0, 8'hFF); chk("t3_back1", int'(pc_a), 19);
        step(0, 0, 0, 1, 0, 8'h03); chk("t3_fwd3", int'(pc_a), 22);
        step(0, 0, 1, 0, 0, 8'h02); chk("t3_pc2", int'(pc_a), 2);
        step(0, 0, 0, 1, 0, 8'hFC); chk("t3_wrap", int'(pc_a), 1022);
        nop(1); chk("t3_1023", int'(pc_a), 1023);
        nop(1); chk("t3_inc_wrap", int'(pc_a), 0);
        chk("t3_cnt", int'(cnt_a), 17);
        chk("t6_sat4", int'(cnt_b), 15);

        // T4 priority
        step(0, 0, 1, 1, 0, 8'h1F); chk("t4_jump_wins", int'(pc_a), 31);
        step(0, 1, 1, 0, 0, 8'h05); chk("t4_stall_holds", int'(pc_a), 31);
        step(0, 1, 0, 0, 1, 8'h00);
        chk("t4_halt_done", int'(done_a), 1);
        chk("t4_halt_run", int'(run_a), 0);
        chk("t4_halt_pc", int'(pc_a), 31);
        chk("t4_cnt", int'(cnt_a), 20);
        step(0, 0, 1, 0, 0, 8'hAA); chk("t4_done_ignores", int'(pc_a), 31);

        // T5 halt after 7 run cycles, freeze, restart
        step(1, 0, 0, 0, 0, 8'h00);
        chk("t5_start_pc", int'(pc_a), 0);
        chk("t5_start_cnt", int'(cnt_a), 0);
        chk("t5_start_done", int'(done_a), 0);
        nop(6); chk("t5_pc6", int'(pc_a), 6);
        step(0, 0, 0, 0, 1, 8'h00);
        chk("t5_done", int'(done_a), 1);
        chk("t5_cnt7", int'(cnt_a), 7);
        for (int i = 0; i < 10; i++) step(0, i[0], i[1], i[2], 1'b1, 8'(i * 37));
        chk("t5_frozen_pc", int'(pc_a), 6);
        chk("t5_frozen_cnt", int'(cnt_a), 7);
        step(1, 0, 0, 0, 0, 8'h00);
        chk("t5_restart_pc", int'(pc_a), 0);
        chk("t5_restart_cnt", int'(cnt_a), 0);
        chk("t5_restart_done", int'(done_a), 0);
        step(1, 0, 0, 0, 0, 8'h00); chk("t5_start_in_run", int'(pc_a), 1);

        // T6 asynchronous reset between edges
        nop(8); chk("t6_pc9", int'(pc_a), 9);
        #2 Reset_n = 1'b0;
        #1;
        chk("t6_async_pc", int'(pc_a), 0);
        chk("t6_async_run", int'(run_a), 0);
        chk("t6_async_cnt", int'(cnt_a), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        step(0, 0, 1, 0, 0, 8'h40);
        chk("t6_idle_pc", int'(pc_a), 0);
        chk("t6_idle_run", int'(run_a), 0);
        nop(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
